// File: rtl/qstate_reg_bank.sv
// qstate_reg_bank
//   Register bank holding the 2**N complex amplitudes of an N-qubit state.
//   Amplitudes can be loaded in parallel, written one at a time, streamed in
//   over a valid/ready channel, or streamed out over a valid/ready channel.
//   The bank only stores data; it never does arithmetic on it.
//
// Parameters
//   N       qubit count; the bank holds 2**N amplitudes
//   DATA_W  signed width of each real and imaginary part
//   FRAC_W  fractional bits of the fixed-point format (FRAC_W <= DATA_W-2)
//
// Ports
//   clk, rst                     clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready, cmd_op  command handshake; op 00 parallel load,
//                                01 single write, 10 stream load, 11 stream dump
//   idx, wr_data                 single-write index and amplitude
//   A / S                        parallel load vector / current state vector;
//                                amplitude i sits at (2**N-i-1)*2*DATA_W
//   s_valid/s_ready/s_data       stream-in channel (active in LOAD)
//   m_valid/m_ready/m_data/m_last stream-out channel (active in DUMP)
//   abort                        drop an in-progress stream back to IDLE
//   busy                         high whenever not IDLE
//   Every amplitude word is {real, imag}, real in the upper DATA_W bits.
//
// Build option
//   QSTATE_INIT_EN  when defined, amplitude 0 resets to 1.0 + 0i (|0...0>);
//                   otherwise all amplitudes reset to 0.
module qstate_reg_bank #(
  parameter int N      = 2,
  parameter int DATA_W = 32,
  parameter int FRAC_W = DATA_W - 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [N-1:0]                 idx,
  input  logic [2*DATA_W-1:0]          wr_data,
  input  logic [(2**N)*2*DATA_W-1:0]   A,
  output logic [(2**N)*2*DATA_W-1:0]   S,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [2*DATA_W-1:0]          s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [2*DATA_W-1:0]          m_data,
  output logic                         m_last,
  input  logic                         abort,
  output logic                         busy
);

  localparam int NA    = 2**N;
  localparam int AMP_W = 2*DATA_W;

  localparam logic [1:0] OP_PLOAD = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SLOAD = 2'b10;
  localparam logic [1:0] OP_SDUMP = 2'b11;

  localparam logic [N-1:0] CNT_LAST = N'(NA-1);
  localparam logic [N-1:0] CNT_ONE  = N'(1);

`ifdef QSTATE_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  // 1.0 in the fixed-point format; FRAC_W <= DATA_W-2 keeps it positive.
  localparam logic [DATA_W-1:0] FX_ONE   = DATA_W'(1) << FRAC_W;
  localparam logic [AMP_W-1:0]  AMP0_RST = INIT_EN ? {FX_ONE, {DATA_W{1'b0}}}
                                                   : '0;

  typedef enum logic [1:0] {IDLE, LOAD, DUMP} state_e;

  state_e                      state_q, state_d;
  logic [N-1:0]                cnt_q, cnt_d;
  logic [NA-1:0][AMP_W-1:0]    amp_q, amp_d;
  logic [NA-1:0][AMP_W-1:0]    a_vec;

  // Amplitude 0 lives in the most significant slot of A and S.
  for (genvar i = 0; i < NA; i++) begin : g_map
    assign a_vec[i]                          = A[(NA-1-i)*AMP_W +: AMP_W];
    assign S[(NA-1-i)*AMP_W +: AMP_W]        = amp_q[i];
  end

  // Handshake outputs depend on state only, so an async reset clears them
  // immediately.
  assign cmd_ready = (state_q == IDLE);
  assign busy      = !cmd_ready;
  assign s_ready   = (state_q == LOAD);
  assign m_valid   = (state_q == DUMP);
  assign m_last    = m_valid && (cnt_q == CNT_LAST);
  // cnt only moves on a handshake, which keeps m_data stable under backpressure.
  assign m_data    = amp_q[cnt_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    amp_d   = amp_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          unique case (cmd_op)
            OP_PLOAD: amp_d = a_vec;
            OP_WRITE: amp_d[idx] = wr_data;
            OP_SLOAD: begin
              cnt_d   = '0;
              state_d = LOAD;
            end
            OP_SDUMP: begin
              cnt_d   = '0;
              state_d = DUMP;
            end
            default: ;
          endcase
        end
      end
      LOAD: begin
        // A beat arriving together with abort is still stored.
        if (s_valid) begin
          amp_d[cnt_q] = s_data;
          cnt_d        = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) state_d = IDLE;
        end
        if (abort) state_d = IDLE;
      end
      DUMP: begin
        if (m_ready) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) state_d = IDLE;
        end
        if (abort) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      amp_q    <= '0;
      amp_q[0] <= AMP0_RST;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      amp_q    <= amp_d;
    end
  end

endmodule

// File: tb/tb_qstate_reg_bank.sv
module tb_qstate_reg_bank;
  localparam int N  = 2;
  localparam int DW = 16;
  localparam int FW = 14;
  localparam int NA = 4;
  localparam int AW = NA*2*DW;

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid, cmd_ready;
  logic [1:0]     cmd_op;
  logic [N-1:0]   idx;
  logic [2*DW-1:0] wr_data;
  logic [AW-1:0]  A, S;
  logic           s_valid, s_ready;
  logic [2*DW-1:0] s_data;
  logic           m_valid, m_ready, m_last;
  logic [2*DW-1:0] m_data;
  logic           abort, busy;

  qstate_reg_bank #(.N(N), .DATA_W(DW), .FRAC_W(FW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .idx(idx), .wr_data(wr_data), .A(A), .S(S),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .abort(abort), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: amplitude list plus "what transfer is running, how far".
  logic [31:0] amp [NA];
  int          mode;   // 0 idle, 1 streaming in, 2 streaming out
  int          pos;

  task automatic chk(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] model_s();
    logic [AW-1:0] r;
    for (int i = 0; i < NA; i++) r[(NA-1-i)*32 +: 32] = amp[i];
    return r;
  endfunction

  function automatic logic [AW-1:0] reset_s();
    logic [AW-1:0] r;
    r = '0;
`ifdef QSTATE_INIT_EN
    r[127:96] = 32'h4000_0000;
`endif
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NA; i++) amp[i] = 32'h0;
`ifdef QSTATE_INIT_EN
    amp[0] = 32'h4000_0000;
`endif
    mode = 0;
    pos  = 0;
  endtask

  task automatic check_all();
    chk("S", S, model_s());
    chk("cmd_ready", cmd_ready, mode == 0);
    chk("busy", busy, mode != 0);
    chk("s_ready", s_ready, mode == 1);
    chk("m_valid", m_valid, mode == 2);
    chk("m_last", m_last, (mode == 2) && (pos == NA-1));
    if (mode == 2) chk("m_data", m_data, amp[pos]);
  endtask

  // Applies the inputs seen at a clock edge to the model.
  task automatic model_step();
    if (mode == 0) begin
      if (cmd_valid) begin
        case (cmd_op)
          2'b00: for (int i = 0; i < NA; i++) amp[i] = A[(NA-1-i)*32 +: 32];
          2'b01: amp[idx] = wr_data;
          2'b10: begin mode = 1; pos = 0; end
          default: begin mode = 2; pos = 0; end
        endcase
      end
    end else begin
      if (mode == 1 && s_valid) begin
        amp[pos] = s_data;
        if (pos == NA-1) mode = 0;
        pos = (pos + 1) % NA;
      end else if (mode == 2 && m_ready) begin
        if (pos == NA-1) mode = 0;
        pos = (pos + 1) % NA;
      end
      if (abort) mode = 0;
    end
  endtask

  // Called at a falling edge with inputs already set.
  task automatic tick();
    check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; cmd_op = 0; idx = 0; wr_data = 0; A = '0;
    s_valid = 0; s_data = 0; m_ready = 0; abort = 0;
  endtask

  initial begin
    logic [31:0] words [4];
    logic [4:0]  mr_pat;
    int          beat;
    words[0] = 32'h1111_0000; words[1] = 32'h2222_0000;
    words[2] = 32'h3333_0000; words[3] = 32'h4444_0000;

    rst = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    check_all();
    chk("rst_S", S, reset_s());
    rst = 1'b1;
    tick();
    chk("post_rst_S", S, reset_s());

    // Parallel load
    cmd_valid = 1; cmd_op = 2'b00;
    A = {32'h0001_0002, 32'h0003_0004, 32'h0005_0006, 32'h0007_0008};
    tick();
    cmd_valid = 0; A = '0;
    chk("pload_S", S, {32'h0001_0002, 32'h0003_0004, 32'h0005_0006, 32'h0007_0008});
    chk("pload_ready", cmd_ready, 1'b1);

    // Single write
    cmd_valid = 1; cmd_op = 2'b01; idx = 2; wr_data = 32'hC000_4000;
    tick();
    cmd_valid = 0; idx = 0; wr_data = 0;
    chk("write_S", S, {32'h0001_0002, 32'h0003_0004, 32'hC000_4000, 32'h0007_0008});

    // Stream load with gaps
    cmd_valid = 1; cmd_op = 2'b10;
    tick();
    cmd_valid = 0; cmd_op = 2'b01; idx = 3; wr_data = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      s_valid = 0; s_data = 32'hFFFF_FFFF;
      tick();
      s_valid = 1; s_data = words[k];
      tick();
    end
    s_valid = 0; s_data = 0; wr_data = 0; idx = 0;
    chk("sload_busy", busy, 1'b0);
    chk("sload_S", S, {words[0], words[1], words[2], words[3]});

    // Stream dump with backpressure 1,0,1,1,1
    cmd_valid = 1; cmd_op = 2'b11;
    tick();
    cmd_valid = 0;
    mr_pat = 5'b11101;
    beat = 0;
    for (int j = 0; j < 5; j++) begin
      chk("dump_valid", m_valid, 1'b1);
      chk("dump_data", m_data, words[beat]);
      chk("dump_last", m_last, beat == 3);
      m_ready = mr_pat[j];
      tick();
      if (mr_pat[j]) beat++;
    end
    m_ready = 0;
    chk("dump_done", busy, 1'b0);

    // Stream load aborted after two words
    cmd_valid = 1; cmd_op = 2'b10;
    tick();
    cmd_valid = 0;
    s_valid = 1; s_data = 32'hAAAA_0001; tick();
    s_data = 32'hBBBB_0002; tick();
    s_valid = 0; abort = 1; tick();
    abort = 0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_S", S, {32'hAAAA_0001, 32'hBBBB_0002, words[2], words[3]});
    cmd_valid = 1; cmd_op = 2'b01; idx = 3; wr_data = 32'h1234_5678; tick();
    cmd_valid = 0;
    chk("post_abort_write", S, {32'hAAAA_0001, 32'hBBBB_0002, words[2], 32'h1234_5678});

    // Abort in IDLE does nothing; command alongside it is still accepted
    abort = 1; cmd_valid = 1; cmd_op = 2'b01; idx = 0; wr_data = 32'h0BAD_F00D; tick();
    abort = 0; cmd_valid = 0;
    chk("idle_abort", S, {32'h0BAD_F00D, 32'hBBBB_0002, words[2], 32'h1234_5678});

    // Async reset mid-dump, away from a clock edge
    cmd_valid = 1; cmd_op = 2'b11; tick();
    cmd_valid = 0; m_ready = 0; tick();
    #2 rst = 1'b0;
    #1;
    chk("async_busy", busy, 1'b0);
    chk("async_m_valid", m_valid, 1'b0);
    chk("async_S", S, reset_s());
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      cmd_valid = ($urandom_range(0, 9) < 3);
      cmd_op    = 2'($urandom_range(0, 3));
      idx       = 2'($urandom_range(0, 3));
      wr_data   = $urandom;
      A         = {$urandom, $urandom, $urandom, $urandom};
      s_valid   = ($urandom_range(0, 9) < 6);
      s_data    = $urandom;
      m_ready   = ($urandom_range(0, 9) < 6);
      abort     = ($urandom_range(0, 39) == 0);
      tick();
    end
    idle_inputs();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
